// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped data cache: FSM states, RV32I load/store
// width codes and the per-line record.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Tag field is sized for the widest tag; narrower tags are zero-extended.
  localparam int LINE_TAG_W  = 32;
  localparam int LINE_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [LINE_TAG_W-1:0]  tag;
    logic [LINE_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side request/response and data_memory-side refill/write-back signals
// of the data cache, bundled with one modport per side.
interface data_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read_enable;
  logic                  write_enable;
  logic [2:0]            func3;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [ADDR_WIDTH-1:0] dirty_add;
  logic [DATA_WIDTH-1:0] dirty_data;
  logic                  dirty_en;
  logic [DATA_WIDTH-1:0] new_data;

  modport slave (
    input  read_enable, write_enable, func3, address, write_data, new_data,
    output read_data, stall, mem_address, dirty_add, dirty_data, dirty_en
  );

  modport master (
    output read_enable, write_enable, func3, address, write_data, new_data,
    input  read_data, stall, mem_address, dirty_add, dirty_data, dirty_en
  );
endinterface

// File: rtl/dcache_byte_lane.sv
// Combinational byte-lane steering: load extract/extend and store byte-merge
// for one 32-bit line, selected by func3 and the address byte offset.
module dcache_byte_lane
  import dcache_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] store_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_pos;

  assign byte_pos = {offset_i, 3'b000};
  assign byte_sel = word_i[byte_pos +: 8];
  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    load_o  = '0;
    merge_o = store_i;
    unique case (func3_i)
      F3_B, F3_BU: begin
        load_o  = (func3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        merge_o = word_i;
        merge_o[byte_pos +: 8] = store_i[7:0];
      end
      F3_H, F3_HU: begin
        load_o  = (func3_i == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        merge_o = offset_i[1] ? {store_i[15:0], word_i[15:0]} : {word_i[31:16], store_i[15:0]};
      end
      F3_W:    load_o = word_i;
      default: ;  // undefined width: load reads 0, store writes the whole word
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8
) (
  input  logic         clk,
  input  logic         rst,
  data_cache_if.slave  bus,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  state_e                state_q, state_d;
  logic [SETS-1:0]       valid_q;
  logic [SETS-1:0]       dirty_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  logic [IDX-1:0]        idx;
  logic [TAG_W-1:0]      tag;
  line_t                 cur;
  logic                  req, hit;
  logic                  store_hit, fill;
  logic [31:0]           load_word, merged_word;
  logic [DATA_WIDTH-1:0] read_data, dirty_data;
  logic [ADDR_WIDTH-1:0] dirty_add;
  logic                  stall, dirty_en;

  assign idx = bus.address[IDX+1:2];
  assign tag = bus.address[ADDR_WIDTH-1:IDX+2];
  assign req = bus.read_enable | bus.write_enable;

  always_comb begin
    cur       = '0;
    cur.valid = valid_q[idx];
    cur.dirty = dirty_q[idx];
    cur.tag   = LINE_TAG_W'(tag_q[idx]);
    cur.data  = data_q[idx];
  end

  assign hit = cur.valid && (cur.tag == LINE_TAG_W'(tag));

  dcache_byte_lane u_lane (
    .func3_i  (bus.func3),
    .offset_i (bus.address[1:0]),
    .word_i   (cur.data),
    .store_i  (bus.write_data),
    .load_o   (load_word),
    .merge_o  (merged_word)
  );

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    dirty_en   = 1'b0;
    dirty_add  = '0;
    dirty_data = '0;
    read_data  = '0;
    store_hit  = 1'b0;
    fill       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          if (bus.read_enable) read_data = load_word;
          store_hit = bus.write_enable;
        end else if (req) begin
          stall   = 1'b1;
          state_d = (cur.valid && cur.dirty) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        stall      = 1'b1;
        dirty_en   = 1'b1;
        dirty_add  = {cur.tag[TAG_W-1:0], idx, 2'b00};
        dirty_data = cur.data;
        state_d    = FILL;
      end
      FILL: begin
        stall   = 1'b1;
        fill    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset wins immediately so an aborted write-back never reaches memory.
    if (rst) begin
      stall      = 1'b0;
      dirty_en   = 1'b0;
      dirty_add  = '0;
      dirty_data = '0;
      read_data  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag/data storage has no reset; valid_q alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill) begin
        tag_q[idx]  <= tag;
        data_q[idx] <= bus.new_data;
      end else if (store_hit) begin
        data_q[idx] <= merged_word;
      end
    end
  end

  assign bus.read_data   = read_data;
  assign bus.stall       = stall;
  assign bus.mem_address = {bus.address[ADDR_WIDTH-1:2], 2'b00};
  assign bus.dirty_add   = dirty_add;
  assign bus.dirty_data  = dirty_data;
  assign bus.dirty_en    = dirty_en;

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_count_q, miss_count_q;

  assign hit_evt  = (state_q == IDLE) && req && hit;
  assign miss_evt = (state_q == IDLE) && req && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_evt)  hit_count_q  <= hit_count_q + 32'd1;
      if (miss_evt) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
